elev_call_scheduler: RTL and testbench

- Upstream stage of elevator_design.
- Latches hall/car call buttons into a pending-request register and watches the current floor reported back by elevator_design (its outfloor).
- Runs a direction-preserving (SCAN) state machine.
- Drives elevator_design's up/down/inf inputs and adds door dwell timing.
- Sits between the button-panel synchronisers and elevator_design, in the same clock domain.

---
 rtl/elev_pkg.sv | 25 ++
 rtl/elev_target_sel.sv | 73 +++++++
 rtl/elev_call_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_elev_call_scheduler.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/elev_pkg.sv
// Shared types and defaults for the elevator call scheduler and elevator_design.
package elev_pkg;

  localparam int DEF_NUM_FLOORS = 8;
  localparam int DEF_FLOOR_W    = 3;

  typedef enum logic [1:0] {
    IDLE,
    MOVE_UP,
    MOVE_DOWN,
    DOOR
  } state_e;

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_e;

  typedef enum logic [1:0] {
    SEL_NEAREST,
    SEL_ABOVE,
    SEL_BELOW
  } sel_mode_e;

endpackage

// File: rtl/elev_target_sel.sv
// Combinational target search over the pending-call vector.
// ABOVE: lowest pending floor strictly above cur_floor.
// BELOW: highest pending floor strictly below cur_floor.
// NEAREST: closer of the two, ties go to the floor above.
module elev_target_sel
  import elev_pkg::*;
#(
  parameter int NUM_FLOORS = DEF_NUM_FLOORS,
  parameter int FLOOR_W    = DEF_FLOOR_W
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  sel_mode_e             mode,
  output logic                  found,
  output logic [FLOOR_W-1:0]    floor
);

  logic               above_found;
  logic               below_found;
  logic [FLOOR_W-1:0] above_floor;
  logic [FLOOR_W-1:0] below_floor;
  logic [FLOOR_W:0]   dist_above;
  logic [FLOOR_W:0]   dist_below;

  // Priority scans: the closest qualifying floor is visited last and wins
  always_comb begin
    above_found = 1'b0;
    above_floor = '0;
    below_found = 1'b0;
    below_floor = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && (i > int'(cur_floor))) begin
        above_found = 1'b1;
        above_floor = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && (i < int'(cur_floor))) begin
        below_found = 1'b1;
        below_floor = FLOOR_W'(i);
      end
    end
  end

  assign dist_above = {1'b0, above_floor} - {1'b0, cur_floor};
  assign dist_below = {1'b0, cur_floor} - {1'b0, below_floor};

  // Mode select; nearest prefers the floor above on an equal distance
  always_comb begin
    found = 1'b0;
    floor = cur_floor;
    case (mode)
      SEL_ABOVE: begin
        found = above_found;
        floor = above_floor;
      end
      SEL_BELOW: begin
        found = below_found;
        floor = below_floor;
      end
      default: begin
        if (above_found && (!below_found || (dist_above <= dist_below))) begin
          found = 1'b1;
          floor = above_floor;
        end else if (below_found) begin
          found = 1'b1;
          floor = below_floor;
        end
      end
    endcase
  end

endmodule

// File: rtl/elev_call_scheduler.sv
// SCAN call scheduler in front of elevator_design: latches calls, picks the
// next floor, drives up/down/target and times the door dwell.
module elev_call_scheduler
  import elev_pkg::*;
#(
  parameter int NUM_FLOORS  = DEF_NUM_FLOORS,
  parameter int FLOOR_W     = DEF_FLOOR_W,
  parameter int DOOR_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic [FLOOR_W-1:0]    cur_floor,
  output logic                  up,
  output logic                  down,
  output logic [FLOOR_W-1:0]    target,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  busy
);

  localparam int                 DW         = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [DW-1:0]      DWELL_LOAD = DW'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR  = FLOOR_W'(NUM_FLOORS - 1);

  state_e                  state_q, state_d;
  dir_e                    dir_q, dir_d;
  logic [DW-1:0]           dwell_q, dwell_d;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  logic                    up_q, up_d;
  logic                    down_q, down_d;
  logic [FLOOR_W-1:0]      target_q, target_d;
  logic                    door_q, door_d;

  logic [FLOOR_W-1:0]      cur_eff;
  logic [NUM_FLOORS-1:0]   cur_bit;
  logic [NUM_FLOORS-1:0]   pend_eff;
  logic [NUM_FLOORS-1:0]   clr_mask;
  logic                    near_found, up_found, dn_found;
  logic [FLOOR_W-1:0]      near_floor, up_floor, dn_floor;

  // Out-of-range floor readings are treated as the top floor
  assign cur_eff  = (cur_floor > TOP_FLOOR) ? TOP_FLOOR : cur_floor;
  assign cur_bit  = NUM_FLOORS'(1) << cur_eff;
  // Calls arriving this cycle take part in this cycle's decision
  assign pend_eff = pending_q | call_req;

  elev_target_sel #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_sel_near (
    .pending(pend_eff), .cur_floor(cur_eff), .mode(SEL_NEAREST),
    .found(near_found), .floor(near_floor)
  );

  elev_target_sel #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_sel_up (
    .pending(pend_eff), .cur_floor(cur_eff), .mode(SEL_ABOVE),
    .found(up_found), .floor(up_floor)
  );

  elev_target_sel #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_sel_dn (
    .pending(pend_eff), .cur_floor(cur_eff), .mode(SEL_BELOW),
    .found(dn_found), .floor(dn_floor)
  );

  // Next-state and registered-output decisions for the SCAN controller
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    dwell_d  = dwell_q;
    up_d     = 1'b0;
    down_d   = 1'b0;
    door_d   = 1'b0;
    target_d = target_q;
    case (state_q)
      IDLE: begin
        if (|(pend_eff & cur_bit)) begin
          state_d  = DOOR;
          door_d   = 1'b1;
          target_d = cur_eff;
          dwell_d  = DWELL_LOAD;
        end else if (near_found) begin
          target_d = near_floor;
          if (near_floor > cur_eff) begin
            state_d = MOVE_UP;
            up_d    = 1'b1;
          end else begin
            state_d = MOVE_DOWN;
            down_d  = 1'b1;
          end
        end
      end
      MOVE_UP: begin
        if (cur_eff == target_q) begin
          state_d  = DOOR;
          dir_d    = DIR_UP;
          door_d   = 1'b1;
          target_d = cur_eff;
          dwell_d  = DWELL_LOAD;
        end else if (up_found) begin
          up_d     = 1'b1;
          target_d = up_floor;
        end else begin
          state_d = IDLE;
        end
      end
      MOVE_DOWN: begin
        if (cur_eff == target_q) begin
          state_d  = DOOR;
          dir_d    = DIR_DOWN;
          door_d   = 1'b1;
          target_d = cur_eff;
          dwell_d  = DWELL_LOAD;
        end else if (dn_found) begin
          down_d   = 1'b1;
          target_d = dn_floor;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        door_d   = 1'b1;
        target_d = cur_eff;
        if (|(call_req & cur_bit)) begin
          dwell_d = DWELL_LOAD;
        end else if (dwell_q != '0) begin
          dwell_d = dwell_q - DW'(1);
        end else begin
          door_d = 1'b0;
          if (up_found && ((dir_q == DIR_UP) || !dn_found)) begin
            state_d  = MOVE_UP;
            up_d     = 1'b1;
            target_d = up_floor;
          end else if (dn_found) begin
            state_d  = MOVE_DOWN;
            down_d   = 1'b1;
            target_d = dn_floor;
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  // The served floor's call is absorbed while the door is (or is about to be) open
  always_comb begin
    clr_mask = '0;
    if ((state_q == DOOR) || (state_d == DOOR)) clr_mask = cur_bit;
    pending_d = pend_eff & ~clr_mask;
  end

  // State and output registers; reset drops all calls immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      dir_q     <= DIR_UP;
      dwell_q   <= '0;
      pending_q <= '0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      target_q  <= '0;
      door_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      dwell_q   <= dwell_d;
      pending_q <= pending_d;
      up_q      <= up_d;
      down_q    <= down_d;
      target_q  <= target_d;
      door_q    <= door_d;
    end
  end

  assign up        = up_q;
  assign down      = down_q;
  assign target    = target_q;
  assign door_open = door_q;
  assign pending   = pending_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_elev_call_scheduler.sv
// Bench for elev_call_scheduler: directed scenarios plus a random car walk,
// all checked against a floor-level behavioural model of the scheduler.
module tb_elev_call_scheduler;

  localparam int NF = 8;
  localparam int FW = 3;
  localparam int DC = 4;

  localparam int S_IDLE = 0;
  localparam int S_UP   = 1;
  localparam int S_DN   = 2;
  localparam int S_DOOR = 3;

  logic          clk;
  logic          rst;
  logic [NF-1:0] call_req;
  logic [FW-1:0] cur_floor;
  logic          up, down, door_open, busy;
  logic [FW-1:0] target;
  logic [NF-1:0] pending;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model: what the scheduler should be showing after the last edge
  logic [NF-1:0] m_pend;
  int            m_state;
  int            m_dir_up;
  int            m_left;
  logic          m_up, m_down, m_door;
  int            m_tgt;

  elev_call_scheduler #(.NUM_FLOORS(NF), .FLOOR_W(FW), .DOOR_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .call_req(call_req), .cur_floor(cur_floor),
    .up(up), .down(down), .target(target), .door_open(door_open),
    .pending(pending), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete (observed running, expected finished)");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int lowest_above(input logic [NF-1:0] p, input int c);
    for (int f = c + 1; f < NF; f++) if (p[f]) return f;
    return -1;
  endfunction

  function automatic int highest_below(input logic [NF-1:0] p, input int c);
    for (int f = c - 1; f >= 0; f--) if (p[f]) return f;
    return -1;
  endfunction

  // Walk outwards one floor at a time, looking up before down (tie goes up)
  function automatic int nearest(input logic [NF-1:0] p, input int c);
    for (int d = 1; d < NF; d++) begin
      if ((c + d < NF) && p[c + d]) return c + d;
      if ((c - d >= 0) && p[c - d]) return c - d;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_state = S_IDLE; m_dir_up = 1; m_left = 0;
    m_up = 0; m_down = 0; m_door = 0; m_tgt = 0;
  endtask

  task automatic open_door(input int c);
    m_state = S_DOOR; m_door = 1; m_tgt = c; m_left = DC;
  endtask

  task automatic model_step(input logic [NF-1:0] call, input int floor);
    logic [NF-1:0] pe;
    int c, la, hb, nr, prev;
    pe   = m_pend | call;
    c    = (floor > NF - 1) ? NF - 1 : floor;
    prev = m_state;
    m_up = 0; m_down = 0; m_door = 0;
    la   = lowest_above(pe, c);
    hb   = highest_below(pe, c);
    case (prev)
      S_IDLE: begin
        if (pe[c]) open_door(c);
        else if (pe != '0) begin
          nr = nearest(pe, c);
          m_tgt = nr;
          if (nr > c) begin m_state = S_UP; m_up = 1; end
          else begin m_state = S_DN; m_down = 1; end
        end
      end
      S_UP: begin
        if (c == m_tgt) begin open_door(c); m_dir_up = 1; end
        else if (la >= 0) begin m_tgt = la; m_up = 1; end
        else m_state = S_IDLE;
      end
      S_DN: begin
        if (c == m_tgt) begin open_door(c); m_dir_up = 0; end
        else if (hb >= 0) begin m_tgt = hb; m_down = 1; end
        else m_state = S_IDLE;
      end
      default: begin
        m_tgt = c;
        if (call[c]) m_left = DC;
        else m_left = m_left - 1;
        if (m_left > 0) m_door = 1;
        else if ((m_dir_up == 1 && la >= 0) || (m_dir_up == 0 && hb < 0 && la >= 0)) begin
          m_state = S_UP; m_up = 1; m_tgt = la;
        end else if (hb >= 0) begin
          m_state = S_DN; m_down = 1; m_tgt = hb;
        end else m_state = S_IDLE;
      end
    endcase
    if (prev == S_DOOR || m_state == S_DOOR) pe[c] = 1'b0;
    m_pend = pe;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".up"},      32'(up),        32'(m_up));
    chk({tag, ".down"},    32'(down),      32'(m_down));
    chk({tag, ".target"},  32'(target),    32'(m_tgt));
    chk({tag, ".door"},    32'(door_open), 32'(m_door));
    chk({tag, ".pending"}, 32'(pending),   32'(m_pend));
    chk({tag, ".busy"},    32'(busy),      32'(m_state != S_IDLE));
  endtask

  task automatic step(input logic [NF-1:0] call, input int floor, input string tag);
    @(negedge clk);
    call_req  = call;
    cur_floor = FW'(floor);
    model_step(call, floor);
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic dwell_then_leave(input int floor, input string tag);
    for (int i = 0; i < DC - 1; i++) begin
      step('0, floor, tag);
      chk({tag, ".door_hold"}, 32'(door_open), 32'd1);
    end
    step('0, floor, tag);
    chk({tag, ".door_fall"}, 32'(door_open), 32'd0);
  endtask

  initial begin
    logic [NF-1:0] rc;
    int car;
    rst = 1'b1; call_req = '0; cur_floor = '0;
    model_reset();
    #1;
    chk("reset.up", 32'(up), 32'd0);
    chk("reset.down", 32'(down), 32'd0);
    chk("reset.target", 32'(target), 32'd0);
    chk("reset.door", 32'(door_open), 32'd0);
    chk("reset.pending", 32'(pending), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single call to floor 3 from the ground
    step(8'h08, 0, "s1");
    chk("s1.up", 32'(up), 32'd1);
    chk("s1.target", 32'(target), 32'd3);
    chk("s1.busy", 32'(busy), 32'd1);
    step('0, 3, "s1");
    chk("s1.arrive_up", 32'(up), 32'd0);
    chk("s1.arrive_door", 32'(door_open), 32'd1);
    chk("s1.arrive_pend", 32'(pending), 32'd0);
    dwell_then_leave(3, "s1");
    chk("s1.idle", 32'(busy), 32'd0);

    // Intermediate call overtakes the current target
    step(8'h40, 1, "s2");
    chk("s2.target6", 32'(target), 32'd6);
    step('0, 2, "s2");
    step(8'h10, 2, "s2");
    chk("s2.retarget", 32'(target), 32'd4);
    step('0, 3, "s2");
    step('0, 4, "s2");
    chk("s2.door4", 32'(door_open), 32'd1);
    dwell_then_leave(4, "s2");
    chk("s2.resume_up", 32'(up), 32'd1);
    chk("s2.resume_tgt", 32'(target), 32'd6);
    step('0, 5, "s2");
    step('0, 6, "s2");
    dwell_then_leave(6, "s2");

    // Direction preservation: up to 6 first, then down to 1
    step(8'h10, 2, "s3");
    step('0, 3, "s3");
    step(8'h42, 4, "s3");
    chk("s3.pend", 32'(pending), 32'h42);
    dwell_then_leave(4, "s3");
    chk("s3.up6", 32'(up), 32'd1);
    chk("s3.tgt6", 32'(target), 32'd6);
    step('0, 5, "s3");
    step('0, 6, "s3");
    dwell_then_leave(6, "s3");
    chk("s3.down1", 32'(down), 32'd1);
    chk("s3.tgt1", 32'(target), 32'd1);
    for (int f = 5; f >= 1; f--) step('0, f, "s3");
    dwell_then_leave(1, "s3");

    // Equal-distance tie from floor 3 goes up to 5
    step(8'h22, 3, "s4");
    chk("s4.tie_up", 32'(up), 32'd1);
    chk("s4.tie_tgt", 32'(target), 32'd5);
    step('0, 4, "s4");
    step('0, 5, "s4");
    dwell_then_leave(5, "s4");
    chk("s4.down", 32'(down), 32'd1);
    chk("s4.tgt1", 32'(target), 32'd1);
    for (int f = 4; f >= 1; f--) step('0, f, "s4");
    dwell_then_leave(1, "s4");

    // Holding the served floor's button extends the dwell
    step(8'h04, 2, "s5");
    chk("s5.door", 32'(door_open), 32'd1);
    step(8'h04, 2, "s5");
    chk("s5.absorb1", 32'(pending), 32'd0);
    step(8'h04, 2, "s5");
    chk("s5.absorb2", 32'(pending), 32'd0);
    dwell_then_leave(2, "s5");

    // Asynchronous reset mid-descent
    step(8'h81, 2, "s6");
    chk("s6.down", 32'(down), 32'd1);
    chk("s6.tgt0", 32'(target), 32'd0);
    step('0, 1, "s6");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("s6.rst_up", 32'(up), 32'd0);
    chk("s6.rst_down", 32'(down), 32'd0);
    chk("s6.rst_door", 32'(door_open), 32'd0);
    chk("s6.rst_busy", 32'(busy), 32'd0);
    chk("s6.rst_pend", 32'(pending), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step('0, 1, "s6.idle");
      chk("s6.stay_idle", 32'(busy), 32'd0);
    end

    // Random calls with a car that follows up/down at a random pace
    car = 1;
    for (int k = 0; k < 1200; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        if (m_up && car < NF - 1) car++;
        else if (m_down && car > 0) car--;
      end
      rc = '0;
      if ($urandom_range(0, 5) == 0) rc = NF'($urandom);
      else if ($urandom_range(0, 9) == 0) rc = NF'(1) << $urandom_range(0, NF - 1);
      step(rc, car, "rand");
      chk("rand.onehot_dir", 32'(up & down), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
